// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares a single-ported, one-cycle-latency synchronous memory
//                between an instruction-fetch port and a load/store data port.
//                Reads run issue -> wait -> respond; writes complete in the
//                grant cycle. Ties are broken round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_wmask,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    output logic [3:0]    mem_wmask,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_last_d;     // 1: data port was granted most recently
    logic          r_owner_d;    // 1: in-flight read belongs to the data port
    logic [AW-1:0] r_addr;
    logic          r_i_rvalid;
    logic          r_d_rvalid;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_idle;
    logic          w_sel_d;
    logic          w_sel_i;
    logic          w_i_gnt;
    logic          w_d_gnt;
    logic          w_wr_grant;
    logic          w_rd_grant;

    // Grants are only legal in IDLE and never while reset is held, even
    // though the asynchronous reset already parks the state in IDLE.
    assign w_idle     = resetn && (r_state == ST_IDLE);

    // Data wins if it is the only requester, or on a tie when fetch went last.
    assign w_sel_d    = d_req && (!i_req || !r_last_d);
    assign w_sel_i    = i_req && !w_sel_d;

    assign w_i_gnt    = w_idle && w_sel_i;
    assign w_d_gnt    = w_idle && w_sel_d;
    assign w_wr_grant = w_d_gnt && d_we;
    assign w_rd_grant = w_i_gnt || (w_d_gnt && !d_we);

    assign i_gnt      = w_i_gnt;
    assign d_gnt      = w_d_gnt;
    assign mem_rd_en  = w_rd_grant;
    assign mem_wmask  = w_wr_grant ? d_wmask : 4'b0000;
    assign mem_wdata  = w_wr_grant ? d_wdata : '0;

    // The winner's address goes out in the grant cycle; otherwise the
    // address of the last issued read is held.
    assign mem_addr   = !resetn ? '0 :
                        w_i_gnt ? i_addr :
                        w_d_gnt ? d_addr :
                        r_addr;

    assign busy       = (r_state != ST_IDLE);
    assign i_rvalid   = r_i_rvalid;
    assign d_rvalid   = r_d_rvalid;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;

    // Sequencer: arbitration bookkeeping and the issue/wait/respond cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_last_d   <= 1'b1;
            r_owner_d  <= 1'b0;
            r_addr     <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_i_gnt || w_d_gnt) begin
                        r_last_d <= w_d_gnt;
                    end
                    if (w_rd_grant) begin
                        r_owner_d <= w_d_gnt;
                        r_addr    <= w_d_gnt ? d_addr : i_addr;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Response pulse lands in RESP, alongside the captured data.
                    r_i_rvalid <= !r_owner_d;
                    r_d_rvalid <= r_owner_d;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture memory read data into the owning port's holding register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (r_state == ST_WAIT) begin
            if (r_owner_d) begin
                r_d_rdata <= mem_rdata;
            end else begin
                r_i_rdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed vector table,
//                hand-written reset/contention/write sequences, and a
//                randomized run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic        mem_rd_en;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_wmask   (d_wmask),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory attached to the arbiter ----------------
    logic [31:0] mem [0:255];
    logic        do_init;

    function automatic logic [31:0] init_word(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        if (k == 1) return 32'h00A08093;
        if (k == 2) return 32'h11112222;
        return 32'h5A00_0000 | (kk << 4);
    endfunction

    always @(posedge clk) begin
        if (do_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dd);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dd;
    endtask

    task automatic apply_reset(input logic init);
        @(posedge clk); #1;
        do_init = init;
        resetn  = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        do_init = 1'b0;
    endtask

    task automatic do_read_d(input logic [31:0] a, input logic [31:0] exp);
        @(posedge clk); #1; drive(0, 0, 1, 0, 4'h0, a, 0); #1;
        chk("rd d_gnt", d_gnt, 1); chk("rd mem_rd_en", mem_rd_en, 1);
        @(posedge clk); #1; drive(0, 0, 0, 0, 4'h0, 0, 0); #1;
        chk("rd d_rvalid early", d_rvalid, 0);
        @(posedge clk); #2;
        chk("rd d_rvalid", d_rvalid, 1); chk("rd d_rdata", d_rdata, exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic dwe; logic [3:0] dm; logic [31:0] da; logic [31:0] dd;
        logic eig; logic edg; logic erd; logic [3:0] ewm; logic eb; logic eirv; logic edrv;
        logic [31:0] eaddr; logic [31:0] edata;
    } vec_t;
    vec_t vq[$];

    task automatic add_v(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dd,
                         input logic eig, input logic edg, input logic erd, input logic [3:0] ewm,
                         input logic eb, input logic eirv, input logic edrv,
                         input logic [31:0] eaddr, input logic [31:0] edata);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dm = dm; v.da = da; v.dd = dd;
        v.eig = eig; v.edg = edg; v.erd = erd; v.ewm = ewm; v.eb = eb;
        v.eirv = eirv; v.edrv = edrv; v.eaddr = eaddr; v.edata = edata;
        vq.push_back(v);
    endtask

    // ---------------- reference model state (random phase) ----------------
    typedef struct { int t; bit pd; logic [31:0] data; } resp_t;
    resp_t       rq[$];
    logic [31:0] ref_mem [0:255];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t       r;
        int          next_free;
        bit          last_d, ip, dp, free, e_i, e_d, e_irv, e_drv;
        logic [31:0] m_i, m_d, ia_r, da_r, dd_r;
        logic        dwe_r;
        logic [3:0]  dm_r;

        // ---- reset state, with requests deliberately present ----
        resetn  = 1'b0;
        do_init = 1'b1;
        drive(1, 32'h4, 1, 1, 4'hF, 32'h8, 32'h12345678);
        repeat (2) @(posedge clk);
        #2;
        chk("rst i_gnt", i_gnt, 0);         chk("rst d_gnt", d_gnt, 0);
        chk("rst mem_rd_en", mem_rd_en, 0); chk("rst mem_wmask", mem_wmask, 0);
        chk("rst busy", busy, 0);           chk("rst i_rvalid", i_rvalid, 0);
        chk("rst d_rvalid", d_rvalid, 0);   chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);     chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        do_init = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 0, 0);
        resetn  = 1'b1;

        // ---- table: tie after reset, write/read, partial write, write vs fetch ----
        //     ir ia     dr we dm    da      dd             ig dg rd wm   b irv drv addr  data
        add_v(1, 'h4,  1, 0, 4'h0, 'h8,  0,             1, 0, 1, 4'h0, 0, 0, 0, 'h4,  0);
        add_v(0, 0,    1, 0, 4'h0, 'h8,  0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    1, 0, 4'h0, 'h8,  0,             0, 0, 0, 4'h0, 1, 1, 0, 0,    'h00A08093);
        add_v(0, 0,    1, 0, 4'h0, 'h8,  0,             0, 1, 1, 4'h0, 0, 0, 0, 'h8,  0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 1, 0,    'h11112222);
        add_v(0, 0,    1, 1, 4'hF, 'h10, 'hDEADBEEF,    0, 1, 0, 4'hF, 0, 0, 0, 'h10, 0);
        add_v(0, 0,    1, 0, 4'h0, 'h10, 0,             0, 1, 1, 4'h0, 0, 0, 0, 'h10, 0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 1, 0,    'hDEADBEEF);
        add_v(0, 0,    1, 1, 4'h5, 'h10, 'h11223344,    0, 1, 0, 4'h5, 0, 0, 0, 'h10, 0);
        add_v(0, 0,    1, 0, 4'h0, 'h10, 0,             0, 1, 1, 4'h0, 0, 0, 0, 'h10, 0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 1, 0,    'hDE22BE44);
        add_v(1, 'h4,  1, 1, 4'hF, 'h14, 'hCAFEF00D,    1, 0, 1, 4'h0, 0, 0, 0, 'h4,  0);
        add_v(0, 0,    1, 1, 4'hF, 'h14, 'hCAFEF00D,    0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    1, 1, 4'hF, 'h14, 'hCAFEF00D,    0, 0, 0, 4'h0, 1, 1, 0, 0,    'h00A08093);
        add_v(0, 0,    1, 1, 4'hF, 'h14, 'hCAFEF00D,    0, 1, 0, 4'hF, 0, 0, 0, 'h14, 0);
        add_v(0, 0,    1, 0, 4'h0, 'h14, 0,             0, 1, 1, 4'h0, 0, 0, 0, 'h14, 0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 1, 0,    'hCAFEF00D);
        add_v(1, 'h8,  1, 0, 4'h0, 'h4,  0,             1, 0, 1, 4'h0, 0, 0, 0, 'h8,  0);
        add_v(0, 0,    1, 0, 4'h0, 'h4,  0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    1, 0, 4'h0, 'h4,  0,             0, 0, 0, 4'h0, 1, 1, 0, 0,    'h11112222);
        add_v(0, 0,    1, 0, 4'h0, 'h4,  0,             0, 1, 1, 4'h0, 0, 0, 0, 'h4,  0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 0, 0,    0);
        add_v(0, 0,    0, 0, 4'h0, 0,    0,             0, 0, 0, 4'h0, 1, 0, 1, 0,    'h00A08093);

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk); #1;
            drive(vq[k].ir, vq[k].ia, vq[k].dr, vq[k].dwe, vq[k].dm, vq[k].da, vq[k].dd);
            #1;
            chk($sformatf("row%0d i_gnt", k), i_gnt, vq[k].eig);
            chk($sformatf("row%0d d_gnt", k), d_gnt, vq[k].edg);
            chk($sformatf("row%0d mem_rd_en", k), mem_rd_en, vq[k].erd);
            chk($sformatf("row%0d mem_wmask", k), mem_wmask, vq[k].ewm);
            chk($sformatf("row%0d busy", k), busy, vq[k].eb);
            chk($sformatf("row%0d i_rvalid", k), i_rvalid, vq[k].eirv);
            chk($sformatf("row%0d d_rvalid", k), d_rvalid, vq[k].edrv);
            if (vq[k].erd || (vq[k].ewm != 4'h0))
                chk($sformatf("row%0d mem_addr", k), mem_addr, vq[k].eaddr);
            if (vq[k].ewm != 4'h0)
                chk($sformatf("row%0d mem_wdata", k), mem_wdata, vq[k].dd);
            if (vq[k].eirv) chk($sformatf("row%0d i_rdata", k), i_rdata, vq[k].edata);
            if (vq[k].edrv) chk($sformatf("row%0d d_rdata", k), d_rdata, vq[k].edata);
        end

        // ---- reset during an in-flight fetch ----
        @(posedge clk); #1; drive(1, 32'h8, 0, 0, 4'h0, 0, 0); #1;
        chk("mid i_gnt c0", i_gnt, 1);
        @(posedge clk); #1; drive(0, 0, 0, 0, 4'h0, 0, 0); resetn = 1'b0; #1;
        chk("mid busy c1", busy, 0); chk("mid i_rvalid c1", i_rvalid, 0); chk("mid i_rdata c1", i_rdata, 0);
        @(posedge clk); #1; drive(1, 32'h4, 0, 0, 4'h0, 0, 0); #1;
        chk("mid i_gnt c2", i_gnt, 0); chk("mid mem_rd_en c2", mem_rd_en, 0);
        chk("mid i_rvalid c2", i_rvalid, 0); chk("mid mem_addr c2", mem_addr, 0);
        @(posedge clk); #1; resetn = 1'b1; drive(0, 0, 0, 0, 4'h0, 0, 0); #1;
        chk("mid i_rvalid c3", i_rvalid, 0); chk("mid busy c3", busy, 0); chk("mid i_rdata c3", i_rdata, 0);
        @(posedge clk); #1; drive(1, 32'h4, 0, 0, 4'h0, 0, 0); #1;
        chk("mid i_gnt c4", i_gnt, 1); chk("mid i_rvalid c4", i_rvalid, 0);
        @(posedge clk); #1; drive(0, 0, 0, 0, 4'h0, 0, 0); #1;
        chk("mid i_rvalid c5", i_rvalid, 0); chk("mid busy c5", busy, 1);
        @(posedge clk); #2;
        chk("mid i_rvalid c6", i_rvalid, 1); chk("mid i_rdata c6", i_rdata, 32'h00A08093);

        // ---- continuous contention from reset: I, D, I, D every third cycle ----
        apply_reset(1'b0);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1; drive(1, 32'h4, 1, 0, 4'h0, 32'h8, 0); #1;
            chk($sformatf("cont c%0d i_gnt", c), i_gnt, (c % 6) == 0);
            chk($sformatf("cont c%0d d_gnt", c), d_gnt, (c % 6) == 3);
            chk($sformatf("cont c%0d busy", c), busy, (c % 3) != 0);
            chk($sformatf("cont c%0d i_rvalid", c), i_rvalid, (c % 6) == 2);
            chk($sformatf("cont c%0d d_rvalid", c), d_rvalid, (c % 6) == 5);
            if ((c % 6) == 2) chk("cont i_rdata", i_rdata, 32'h00A08093);
            if ((c % 6) == 5) chk("cont d_rdata", d_rdata, 32'h11112222);
        end

        // ---- back-to-back writes, then read them back ----
        for (int w = 0; w < 4; w++) begin
            @(posedge clk); #1;
            drive(0, 0, 1, 1, 4'hF, 32'h20 + 32'(4 * w), 32'hA5A5_0000 + 32'(w));
            #1;
            chk($sformatf("b2b w%0d d_gnt", w), d_gnt, 1);
            chk($sformatf("b2b w%0d mem_wmask", w), mem_wmask, 4'hF);
            chk($sformatf("b2b w%0d busy", w), busy, 0);
            chk($sformatf("b2b w%0d mem_addr", w), mem_addr, 32'h20 + 32'(4 * w));
        end
        for (int w = 0; w < 4; w++) do_read_d(32'h20 + 32'(4 * w), 32'hA5A5_0000 + 32'(w));

        // ---- randomized traffic against a transaction-level model ----
        apply_reset(1'b1);
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        next_free = 0; last_d = 1'b1; m_i = '0; m_d = '0; ip = 1'b0; dp = 1'b0;
        ia_r = '0; da_r = '0; dd_r = '0; dwe_r = 1'b0; dm_r = 4'h0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            if (ip && ($urandom_range(0, 15) == 0)) ip = 1'b0;
            else if (!ip && ($urandom_range(0, 3) != 0)) begin
                ip = 1'b1; ia_r = 32'($urandom_range(0, 63)) << 2;
            end
            if (dp && ($urandom_range(0, 15) == 0)) dp = 1'b0;
            else if (!dp && ($urandom_range(0, 3) != 0)) begin
                dp = 1'b1; da_r = 32'($urandom_range(0, 63)) << 2;
                dwe_r = 1'($urandom_range(0, 1)); dm_r = 4'($urandom_range(0, 15)); dd_r = $urandom;
            end
            drive(ip, ia_r, dp, dwe_r, dm_r, da_r, dd_r);
            #1;
            // A read granted at cycle N occupies the memory until N+3.
            free = (t >= next_free);
            e_i = 1'b0; e_d = 1'b0;
            if (free) begin
                if (ip && dp) begin e_i = last_d; e_d = !last_d; end
                else begin e_i = ip; e_d = dp; end
            end
            e_irv = 1'b0; e_drv = 1'b0;
            if ((rq.size() > 0) && (rq[0].t == t)) begin
                r = rq.pop_front();
                if (r.pd) begin e_drv = 1'b1; m_d = r.data; end
                else      begin e_irv = 1'b1; m_i = r.data; end
            end
            chk("rnd i_gnt", i_gnt, e_i);
            chk("rnd d_gnt", d_gnt, e_d);
            chk("rnd mem_rd_en", mem_rd_en, e_i || (e_d && !dwe_r));
            chk("rnd mem_wmask", mem_wmask, (e_d && dwe_r) ? dm_r : 4'h0);
            chk("rnd busy", busy, !free);
            chk("rnd i_rvalid", i_rvalid, e_irv);
            chk("rnd d_rvalid", d_rvalid, e_drv);
            chk("rnd i_rdata", i_rdata, m_i);
            chk("rnd d_rdata", d_rdata, m_d);
            if (e_i) chk("rnd mem_addr i", mem_addr, ia_r);
            if (e_d) chk("rnd mem_addr d", mem_addr, da_r);
            if (e_d && dwe_r) chk("rnd mem_wdata", mem_wdata, dd_r);
            if (e_i) begin
                last_d = 1'b0; next_free = t + 3;
                r.t = t + 2; r.pd = 1'b0; r.data = ref_mem[ia_r[9:2]]; rq.push_back(r);
            end
            if (e_d) begin
                last_d = 1'b1;
                if (dwe_r) begin
                    for (int b = 0; b < 4; b++)
                        if (dm_r[b]) ref_mem[da_r[9:2]][8*b +: 8] = dd_r[8*b +: 8];
                end else begin
                    next_free = t + 3;
                    r.t = t + 2; r.pd = 1'b1; r.data = ref_mem[da_r[9:2]]; rq.push_back(r);
                end
            end
            if (i_gnt) ip = 1'b0;
            if (d_gnt) dp = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported, one-cycle-latency synchronous memory between the processor's instruction-fetch port and its load/store data port. It sits between `Processor` and `Memory` in the SOC and owns the memory's `mem_addr` / `rd_en` / write strobes. It sequences each read through a fixed issue–wait–respond cycle and arbitrates round-robin when both ports request in the same cycle.

## Interface
- `AW`, 32, address width in bits (byte address; memory indexes words with `addr[AW-1:2]`)
- `DW`, 32, data width in bits

- `clk`  in  1  system clock; all state changes on its rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch-port request; held until `i_gnt`
- `i_addr`  in  AW  fetch address, valid while `i_req`=1
- `i_gnt`  out  1  fetch request accepted this cycle
- `i_rvalid`  out  1  one-cycle pulse; `i_rdata` valid
- `i_rdata`  out  DW  fetched word
- `d_req`  in  1  data-port request; held until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_wmask`  in  4  byte-enable mask for writes
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse; `d_rdata` valid (reads only)
- `d_rdata`  out  DW  loaded word
- `mem_addr`  out  AW  memory address
- `mem_rd_en`  out  1  memory read enable (memory samples it on the rising edge)
- `mem_wmask`  out  4  memory byte write strobes; 0 = no write
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory registered read data, valid the cycle after `mem_rd_en`
- `busy`  out  1  1 whenever the state is not IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, selection:**
  - Candidates are `i_req` and `d_req`.
  - If exactly one port requests, that port wins.
  - If both request, the port not granted last wins, per the `last` register.
  - The winner's `gnt` is asserted combinationally in the same cycle.
  - `mem_addr` is driven with the winner's address.
- **IDLE, read grant** (fetch, or data with `d_we`=0):
  - `mem_rd_en`=1.
  - The owner (I or D) and the address are latched.
  - Next state is WAIT.
- **IDLE, write grant** (`d_we`=1):
  - `mem_wmask`=`d_wmask` and `mem_wdata`=`d_wdata` in the same cycle.
  - The write completes at that rising edge; there is no rvalid.
  - The FSM stays in IDLE, so another request can be granted the next cycle.
- **WAIT:**
  - `mem_rdata` is valid.
  - It is captured into the owner's rdata register at the end of the cycle.
  - Next state is RESP.
- **RESP:**
  - The owner's rvalid = 1 for exactly this cycle.
  - Next state is IDLE.
  - No grant is issued in RESP or WAIT.
- `last` updates on every grant (I or D); its reset value is D, so fetch wins the first tie.
- Outside IDLE:
  - `mem_addr` holds the latched address.
  - `mem_rd_en`=0 and `mem_wmask`=0.
  - Both gnt outputs are 0.
- A requester may drop `req` before it is granted, with no side effect.
- A port's rdata register holds its last value until the next read for that port.

## Timing
- Read latency: request accepted in cycle N (gnt=1); rvalid=1 in cycle N+2; next grant possible in cycle N+3.
- Peak read throughput is one access per 3 cycles.
- Peak write throughput is one access per cycle.
- **Reset** (`resetn`=0, asynchronous):
  - State goes to IDLE and `last` goes to D.
  - `i_rdata`, `d_rdata`, `mem_addr` and `mem_wdata` go to 0.
  - rvalids, gnts, `mem_rd_en`, `mem_wmask` and `busy` are forced to 0 while reset is asserted, even if requests are present.
- **Reset during WAIT or RESP:**
  - The in-flight read is discarded and no rvalid is ever produced for it.
  - After reset releases, the first cycle is IDLE with normal arbitration.
- **Simultaneous events:**
  - A request arriving during WAIT or RESP waits for IDLE.
  - If both ports are pending at IDLE, round-robin applies.
  - A data write and a fetch in the same IDLE cycle are also arbitrated; only one of them is granted.

## Test plan
- **Single fetch:** MEM[1]=0x00A08093; `i_req`=1, `i_addr`=0x4 at cycle 0.
  - Cycle 0: `i_gnt`=1, `mem_rd_en`=1, `mem_addr`=0x4.
  - Cycle 2: `i_rvalid`=1, `i_rdata`=0x00A08093.
  - `busy`=1 in cycles 1–2.
- **Tie after reset:** `i_req` and `d_req` (read 0x8) both held from cycle 0.
  - `i_gnt` at cycle 0, `i_rvalid` at cycle 2.
  - `d_gnt` at cycle 3, `d_rvalid` at cycle 5.
- **Write then read:** `d_we`=1, `d_wmask`=4'b1111, `d_addr`=0x10, `d_wdata`=0xDEADBEEF.
  - Same cycle: `d_gnt`=1, `mem_wmask`=4'b1111, `busy` stays 0.
  - Next cycle: a data read of 0x10 is granted; `d_rdata`=0xDEADBEEF two cycles later.
- **Continuous contention:** both ports issue reads continuously for 12 cycles.
  - Grants alternate I, D, I, D at cycles 0, 3, 6, 9.
  - No grant while `busy`=1.
- **Reset mid-read:** fetch granted at cycle 0; `resetn`=0 during cycle 1, released at cycle 3.
  - `i_rvalid` never pulses and `i_rdata`=0.
  - A fetch of 0x4 at cycle 4 completes normally at cycle 6.
- **Back-to-back writes:** `d_req`=1, `d_we`=1 for 4 consecutive cycles, addresses 0x20–0x2C.
  - `d_gnt`=1 in every cycle.
  - Read-back returns all four words.
